// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: fetches the 8-word block of a miss, streams each returned word into the data array, then pulses the tag write.
// Requests issue one per cycle from FILL entry; completion is the cycle of the last return; fsm_busy holds the pipeline for the whole fill.
module cache_fill_fsm #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int MEM_LATENCY     = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               miss_detected,
  input  logic [15:0]                        miss_address,
  output logic                               fsm_busy,
  output logic                               memory_re,
  output logic [15:0]                        memory_address,
  input  logic                               memory_data_valid,
  input  logic [15:0]                        memory_data,
  output logic                               fill_we,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word_idx,
  output logic [15:0]                        fill_data,
  output logic                               write_tag_array
);

  localparam int IDX_W  = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_W  = IDX_W + 1;
  localparam int BASE_W = 16 - IDX_W - 1;
  localparam logic [CNT_W-1:0] REQ_END = CNT_W'(WORDS_PER_BLOCK);

  if ((WORDS_PER_BLOCK < 2) || ((WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0) ||
      (MEM_LATENCY < 1)) begin : g_param_check
    $error("cache_fill_fsm: WORDS_PER_BLOCK must be a power of two >= 2 and MEM_LATENCY >= 1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [BASE_W-1:0]   base_q, base_d;
  logic [CNT_W-1:0]    req_cnt_q, req_cnt_d;
  logic [IDX_W-1:0]    rcv_cnt_q, rcv_cnt_d;
  logic                unused_miss_offset;

  // Byte offset within the block is irrelevant: the whole block is fetched.
  assign unused_miss_offset = ^miss_address[IDX_W:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      base_q    <= '0;
      req_cnt_q <= '0;
      rcv_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      req_cnt_q <= req_cnt_d;
      rcv_cnt_q <= rcv_cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    base_d          = base_q;
    req_cnt_d       = req_cnt_q;
    rcv_cnt_d       = rcv_cnt_q;
    fsm_busy        = 1'b0;
    memory_re       = 1'b0;
    memory_address  = 16'h0000;
    fill_we         = 1'b0;
    fill_word_idx   = '0;
    fill_data       = memory_data;
    write_tag_array = 1'b0;

    case (state_q)
      IDLE: begin
        if (miss_detected) begin
          base_d    = miss_address[15:IDX_W+1];
          req_cnt_d = '0;
          rcv_cnt_d = '0;
          state_d   = FILL;
        end
      end
      FILL: begin
        fsm_busy       = 1'b1;
        memory_re      = (req_cnt_q < REQ_END);
        memory_address = {base_q, req_cnt_q[IDX_W-1:0], 1'b0};
        fill_word_idx  = rcv_cnt_q;
        if (memory_re) begin
          req_cnt_d = req_cnt_q + 1'b1;
        end
        // Returns are in request order, so the receive count alone names the slot.
        if (memory_data_valid) begin
          fill_we   = 1'b1;
          rcv_cnt_d = rcv_cnt_q + 1'b1;
          if (&rcv_cnt_q) begin
            write_tag_array = 1'b1;
            state_d         = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with an in-order fixed-latency memory model and optional return gaps.
module tb_cache_fill_fsm;

  localparam int MEM_LAT = 4;

  logic        clk;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        fsm_busy;
  logic        memory_re;
  logic [15:0] memory_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        fill_we;
  logic [2:0]  fill_word_idx;
  logic [15:0] fill_data;
  logic        write_tag_array;

  int          n_vec;
  int          n_err;
  int          cyc;
  int          gap;
  int          last_ret;
  logic [15:0] pend_addr[$];
  int          pend_due[$];

  cache_fill_fsm #(.WORDS_PER_BLOCK(8), .MEM_LATENCY(MEM_LAT)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .fsm_busy          (fsm_busy),
    .memory_re         (memory_re),
    .memory_address    (memory_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .fill_we           (fill_we),
    .fill_word_idx     (fill_word_idx),
    .fill_data         (fill_data),
    .write_tag_array   (write_tag_array)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Advance one cycle: capture this cycle's request, step the clock, then present any due return.
  task automatic tick();
    if (rst_n && memory_re) begin
      pend_addr.push_back(memory_address);
      pend_due.push_back(cyc + MEM_LAT);
    end
    @(posedge clk);
    #1;
    cyc++;
    memory_data_valid = 1'b0;
    memory_data       = 16'h0000;
    if (pend_due.size() > 0 && pend_due[0] <= cyc && (cyc - last_ret) > gap) begin
      memory_data_valid = 1'b1;
      memory_data       = mem_word(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
      last_ret = cyc;
    end
    #4;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    n_vec++;
    if ({fsm_busy, memory_re, fill_we, write_tag_array} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_flags got %b want 0000", {fsm_busy, memory_re, fill_we, write_tag_array});
    end
    n_vec++;
    if (memory_address !== 16'h0000 || fill_word_idx !== 3'd0) begin
      n_err++;
      $display("FAIL reset_addr got addr %h idx %0d want 0000/0", memory_address, fill_word_idx);
    end
    rst_n = 1'b1;
    tick();
    memory_data_valid = 1'b1;
    memory_data       = 16'h1234;
    #1;
    n_vec++;
    if (fill_we !== 1'b0 || fsm_busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_valid got we %b busy %b want 0 0", fill_we, fsm_busy);
    end
    tick();
    n_vec++;
    if (fsm_busy !== 1'b0 || memory_re !== 1'b0) begin
      n_err++;
      $display("FAIL idle_stay got busy %b re %b want 0 0", fsm_busy, memory_re);
    end
  endtask

  task automatic test_basic();
    logic [3:0]  exp;
    logic [15:0] a;
    miss_address  = 16'h1236;
    miss_detected = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      miss_detected = 1'b0;
      if (c == 13) begin
        memory_data_valid = 1'b1;
        memory_data       = 16'hBEEF;
      end
      #1;
      exp = {c <= 12, c <= 8, (c >= 5 && c <= 12), c == 12};
      n_vec++;
      if ({fsm_busy, memory_re, fill_we, write_tag_array} !== exp) begin
        n_err++;
        $display("FAIL basic_flags c=%0d got %b want %b", c, {fsm_busy, memory_re, fill_we, write_tag_array}, exp);
      end
      if (c <= 8 || c >= 13) begin
        a = (c <= 8) ? 16'h1230 + 16'(2 * (c - 1)) : 16'h0000;
        n_vec++;
        if (memory_address !== a) begin
          n_err++;
          $display("FAIL basic_addr c=%0d got %h want %h", c, memory_address, a);
        end
      end
      if (c >= 5 && c <= 12) begin
        a = 16'h1230 + 16'(2 * (c - 5));
        n_vec++;
        if (fill_word_idx !== 3'(c - 5) || fill_data !== mem_word(a)) begin
          n_err++;
          $display("FAIL basic_word c=%0d got idx %0d data %h want %0d %h", c, fill_word_idx, fill_data, c - 5, mem_word(a));
        end
      end
    end
  endtask

  task automatic test_addr_change();
    logic [15:0] a;
    miss_address  = 16'h1236;
    miss_detected = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      tick();
      miss_detected = (c == 3);
      if (c == 3) miss_address = 16'hFFF0;
      #1;
      if (c <= 8) begin
        a = 16'h1230 + 16'(2 * (c - 1));
        n_vec++;
        if (memory_re !== 1'b1 || memory_address !== a) begin
          n_err++;
          $display("FAIL chg_addr c=%0d got re %b addr %h want 1 %h", c, memory_re, memory_address, a);
        end
      end
      n_vec++;
      if (write_tag_array !== (c == 12) || fsm_busy !== (c <= 12)) begin
        n_err++;
        $display("FAIL chg_tag c=%0d got tag %b busy %b want %b %b", c, write_tag_array, fsm_busy, c == 12, c <= 12);
      end
    end
    miss_address = 16'h0000;
  endtask

  task automatic test_gaps();
    logic [3:0]  exp;
    logic        v;
    logic [15:0] a;
    gap           = 2;
    miss_address  = 16'h0A00;
    miss_detected = 1'b1;
    for (int c = 1; c <= 28; c++) begin
      tick();
      miss_detected = 1'b0;
      #1;
      v   = (c >= 5 && c <= 26 && ((c - 5) % 3) == 0);
      exp = {c <= 26, c <= 8, v, c == 26};
      n_vec++;
      if ({fsm_busy, memory_re, fill_we, write_tag_array} !== exp) begin
        n_err++;
        $display("FAIL gap_flags c=%0d got %b want %b", c, {fsm_busy, memory_re, fill_we, write_tag_array}, exp);
      end
      if (v) begin
        a = 16'h0A00 + 16'(2 * ((c - 5) / 3));
        n_vec++;
        if (fill_word_idx !== 3'((c - 5) / 3) || fill_data !== mem_word(a)) begin
          n_err++;
          $display("FAIL gap_word c=%0d got idx %0d data %h want %0d %h", c, fill_word_idx, fill_data, (c - 5) / 3, mem_word(a));
        end
      end
    end
    gap = 0;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  exp;
    logic        re_e;
    logic [15:0] a;
    miss_address  = 16'h2000;
    miss_detected = 1'b1;
    for (int c = 1; c <= 27; c++) begin
      tick();
      miss_detected = (c <= 13);
      if (c == 13) miss_address = 16'h3000;
      #1;
      re_e = (c <= 8) || (c >= 14 && c <= 21);
      exp  = {(c <= 12) || (c >= 14 && c <= 25), re_e,
              (c >= 5 && c <= 12) || (c >= 18 && c <= 25), (c == 12) || (c == 25)};
      n_vec++;
      if ({fsm_busy, memory_re, fill_we, write_tag_array} !== exp) begin
        n_err++;
        $display("FAIL b2b_flags c=%0d got %b want %b", c, {fsm_busy, memory_re, fill_we, write_tag_array}, exp);
      end
      if (re_e) begin
        a = (c <= 8) ? 16'h2000 + 16'(2 * (c - 1)) : 16'h3000 + 16'(2 * (c - 14));
        n_vec++;
        if (memory_address !== a) begin
          n_err++;
          $display("FAIL b2b_addr c=%0d got %h want %h", c, memory_address, a);
        end
      end
    end
    miss_detected = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [3:0]  exp;
    logic [15:0] a;
    miss_address  = 16'h1236;
    miss_detected = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      miss_detected = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({fsm_busy, memory_re, fill_we, write_tag_array} !== 4'b0000 || memory_address !== 16'h0000) begin
      n_err++;
      $display("FAIL abort_async got %b addr %h want 0000 0000", {fsm_busy, memory_re, fill_we, write_tag_array}, memory_address);
    end
    memory_data_valid = 1'b0;
    pend_addr.delete();
    pend_due.delete();
    tick();
    rst_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      n_vec++;
      if (write_tag_array !== 1'b0 || fsm_busy !== 1'b0) begin
        n_err++;
        $display("FAIL abort_idle c=%0d got tag %b busy %b want 0 0", c, write_tag_array, fsm_busy);
      end
    end
    miss_address  = 16'h0040;
    miss_detected = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      tick();
      miss_detected = 1'b0;
      #1;
      exp = {c <= 12, c <= 8, (c >= 5 && c <= 12), c == 12};
      n_vec++;
      if ({fsm_busy, memory_re, fill_we, write_tag_array} !== exp) begin
        n_err++;
        $display("FAIL refill_flags c=%0d got %b want %b", c, {fsm_busy, memory_re, fill_we, write_tag_array}, exp);
      end
      if (c <= 8) begin
        a = 16'h0040 + 16'(2 * (c - 1));
        n_vec++;
        if (memory_address !== a) begin
          n_err++;
          $display("FAIL refill_addr c=%0d got %h want %h", c, memory_address, a);
        end
      end
      if (c >= 5 && c <= 12) begin
        a = 16'h0040 + 16'(2 * (c - 5));
        n_vec++;
        if (fill_word_idx !== 3'(c - 5) || fill_data !== mem_word(a)) begin
          n_err++;
          $display("FAIL refill_word c=%0d got idx %0d data %h want %0d %h", c, fill_word_idx, fill_data, c - 5, mem_word(a));
        end
      end
    end
  endtask

  initial begin
    n_vec             = 0;
    n_err             = 0;
    cyc               = 0;
    gap               = 0;
    last_ret          = -100;
    rst_n             = 1'b0;
    miss_detected     = 1'b0;
    miss_address      = 16'h0000;
    memory_data_valid = 1'b0;
    memory_data       = 16'h0000;
    test_reset();
    test_basic();
    test_addr_change();
    test_gaps();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
